// File: rtl/seg_scan_3dig_if.sv
// ============================================================================
// Module   : seg_scan_3dig_if
// Brief    : Bus bundle between the segment-code producer and the 3-digit
//            scanner: code load strobe, zero-blank level, scanned outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_scan_3dig_if;
    logic [23:0] code;
    logic        code_valid;
    logic        lz_en;
    logic [7:0]  seg;
    logic [2:0]  dig;
    logic        frame_done;

    // Producer side: supplies codes, observes the display drive
    modport master (
        output code,
        output code_valid,
        output lz_en,
        input  seg,
        input  dig,
        input  frame_done
    );

    // Scanner side
    modport slave (
        input  code,
        input  code_valid,
        input  lz_en,
        output seg,
        output dig,
        output frame_done
    );
endinterface

`default_nettype wire

// File: rtl/seg_scan_3dig.sv
// ============================================================================
// Module   : seg_scan_3dig
// Brief    : Time-multiplexes three 8-bit segment codes onto one segment bus
//            and three digit enables, with frame-boundary (tear-free) update,
//            a blank interval at the start of every digit slot and optional
//            leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_3dig #(
    parameter int DIV         = 50000,
    parameter int BLANK       = 500,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  wire                  clk,
    input  wire                  rst,   // asynchronous, active low
    seg_scan_3dig_if.slave       bus
);

    localparam int             CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLK_END = CNT_W'(BLANK);
    localparam logic [7:0]       ZERO_CODE = 8'hfc;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      shadow_q, shadow_d;
    logic [23:0]      disp_q, disp_d;
    logic             pending_q, pending_d;
    logic             frame_done_q, frame_done_d;

    logic             frame_end;
    logic             slot_wrap;
    logic             hund_sup;
    logic             tens_sup;
    logic             digit_sup;
    logic [7:0]       seg_raw;
    logic [2:0]       dig_raw;

    // Slot counter / digit index advance and the load/transfer datapath
    always_comb begin
        slot_wrap = (cnt_q == CNT_MAX);
        frame_end = slot_wrap && (idx_q == 2'd2);

        cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        shadow_d  = shadow_q;
        pending_d = pending_q;
        disp_d    = disp_q;
        if (bus.code_valid) begin
            shadow_d  = bus.code;
            pending_d = 1'b1;
        end
        // A strobe landing on the frame-end cycle bypasses the shadow so the
        // new value still makes the very next frame.
        if (frame_end) begin
            pending_d = 1'b0;
            if (bus.code_valid) begin
                disp_d = bus.code;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end
        end

        frame_done_d = frame_end;
    end

    // Next-state: evaluated on the upcoming cnt/idx/disp so outputs move on
    // the same edge as the counter. Suppressed digits stay blank all slot.
    always_comb begin
        hund_sup  = bus.lz_en && (disp_d[23:16] == ZERO_CODE);
        tens_sup  = hund_sup && (disp_d[15:8] == ZERO_CODE);
        digit_sup = ((idx_d == 2'd2) && hund_sup) || ((idx_d == 2'd1) && tens_sup);

        state_d = ST_DRIVE;
        if ((cnt_d < BLK_END) || digit_sup) begin
            state_d = ST_BLANK;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= 24'd0;
            disp_q       <= 24'd0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Output decode from registers only, so reset blanks the display at once
    always_comb begin
        seg_raw = 8'h00;
        dig_raw = 3'b000;
        if (state_q == ST_DRIVE) begin
            dig_raw = 3'b001 << idx_q;
            case (idx_q)
                2'd0:    seg_raw = disp_q[7:0];
                2'd1:    seg_raw = disp_q[15:8];
                default: seg_raw = disp_q[23:16];
            endcase
        end
    end

    assign bus.seg        = SEG_ACT_LOW ? ~seg_raw : seg_raw;
    assign bus.dig        = DIG_ACT_LOW ? ~dig_raw : dig_raw;
    assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_3dig.sv
// ============================================================================
// Module   : tb_seg_scan_3dig
// Brief    : Self-checking bench for seg_scan_3dig (DIV=8, BLANK=2,
//            active-low outputs): directed scenarios, random loads, and a
//            cycle-by-cycle comparison against a frame-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_3dig;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 3 * DIV;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    bit   run_cmp;

    seg_scan_3dig_if bus ();

    seg_scan_3dig #(
        .DIV         (DIV),
        .BLANK       (BLANK),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: time since reset release, displayed word, shadow
    // ------------------------------------------------------------------
    int          m_t;
    logic [23:0] m_disp;
    logic [23:0] m_shadow;
    logic        m_pend;
    logic        m_lz;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t      <= 0;
            m_disp   <= 24'd0;
            m_shadow <= 24'd0;
            m_pend   <= 1'b0;
            m_lz     <= 1'b0;
        end else begin
            if ((m_t % FRAME) == FRAME - 1) begin
                m_pend <= 1'b0;
                if (bus.code_valid) begin
                    m_disp   <= bus.code;
                    m_shadow <= bus.code;
                end else if (m_pend) begin
                    m_disp <= m_shadow;
                end
            end else if (bus.code_valid) begin
                m_shadow <= bus.code;
                m_pend   <= 1'b1;
            end
            m_lz <= bus.lz_en;
            m_t  <= m_t + 1;
        end
    end

    function automatic void model_out(output logic [7:0] s, output logic [2:0] d,
                                      output logic fd);
        int         p;
        int         i;
        logic [7:0] b;
        bit         sup;
        s  = 8'hff;
        d  = 3'b111;
        fd = 1'b0;
        if (rst) begin
            p   = m_t % DIV;
            i   = (m_t / DIV) % 3;
            b   = m_disp[8*i +: 8];
            sup = m_lz && (((i == 2) && (m_disp[23:16] == 8'hfc)) ||
                           ((i == 1) && (m_disp[23:16] == 8'hfc) && (m_disp[15:8] == 8'hfc)));
            if ((p >= BLANK) && !sup) begin
                s = ~b;
                d = ~(3'b001 << i);
            end
            fd = (m_t > 0) && ((m_t % FRAME) == 0);
        end
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h expected=%h", name, m_t, got, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [7:0] es;
        logic [2:0] ed;
        logic       ef;
        if (run_cmp) begin
            model_out(es, ed, ef);
            check("seg", bus.seg, es);
            check("dig", {5'd0, bus.dig}, {5'd0, ed});
            check("frame_done", {7'd0, bus.frame_done}, {7'd0, ef});
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic wait_to(input int t);
        int k;
        k = 0;
        while (m_t != t && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (m_t != t) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_to got=%0d expected=%0d", m_t, t);
        end
    endtask

    task automatic pulse_load(input logic [23:0] c);
        bus.code       = c;
        bus.code_valid = 1'b1;
        @(negedge clk);
        bus.code_valid = 1'b0;
    endtask

    task automatic lit(input string name, input int t, input logic [7:0] s, input logic [2:0] d);
        wait_to(t);
        check({name, "_seg"}, bus.seg, s);
        check({name, "_dig"}, {5'd0, bus.dig}, {5'd0, d});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        run_cmp        = 1'b0;
        rst            = 1'b0;
        bus.code       = 24'd0;
        bus.code_valid = 1'b0;
        bus.lz_en      = 1'b0;
        @(negedge clk);
        run_cmp = 1'b1;
        check("rst_seg", bus.seg, 8'hff);
        check("rst_dig", {5'd0, bus.dig}, 8'h07);
        check("rst_fd", {7'd0, bus.frame_done}, 8'h00);
        do_reset();

        // Idle scan with disp = 0
        lit("idle_blank", 1, 8'hff, 3'b111);
        lit("idle_s0", 2, 8'hff, 3'b110);
        lit("idle_s2", 23, 8'hff, 3'b011);
        wait_to(24);
        check("fd_first", {7'd0, bus.frame_done}, 8'h01);

        // "125" loaded mid slot 1 of frame 1; visible from frame 2
        wait_to(34);
        pulse_load(24'h60dab6);
        lit("pre_xfer", 42, 8'hff, 3'b011);
        lit("u125", 50, 8'h49, 3'b110);
        lit("t125", 58, 8'h25, 3'b101);
        lit("h125", 66, 8'h9f, 3'b011);

        // Two loads in one frame, zero blanking on
        bus.lz_en = 1'b1;
        wait_to(74);
        pulse_load(24'hfcfc60);
        wait_to(80);
        pulse_load(24'hfc60f6);
        lit("two_u", 98, 8'h09, 3'b110);
        lit("two_t", 106, 8'h9f, 3'b101);
        lit("two_h", 114, 8'hff, 3'b111);

        // All-zero word with suppression, then suppression released
        wait_to(124);
        pulse_load(24'hfcfcfc);
        lit("lz_u", 146, 8'h03, 3'b110);
        lit("lz_t", 154, 8'hff, 3'b111);
        lit("lz_h", 162, 8'hff, 3'b111);
        wait_to(167);
        bus.lz_en = 1'b0;
        lit("nolz_u", 170, 8'h03, 3'b110);
        lit("nolz_t", 178, 8'h03, 3'b101);
        lit("nolz_h", 186, 8'h03, 3'b011);

        // Strobe on the frame-end cycle goes straight to the display
        wait_to(191);
        pulse_load(24'he0e0e0);
        lit("fe_u", 194, 8'h1f, 3'b110);
        lit("fe_t", 202, 8'h1f, 3'b101);
        lit("fe_h", 210, 8'h1f, 3'b011);
        lit("fe_next", 218, 8'h1f, 3'b110);

        // Random loads and zero-blank toggling
        for (int n = 0; n < 900; n++) begin
            logic [7:0] b [3];
            for (int j = 0; j < 3; j++) begin
                case ($urandom_range(0, 3))
                    0:       b[j] = 8'hfc;
                    1:       b[j] = 8'h00;
                    default: b[j] = 8'($urandom);
                endcase
            end
            bus.code       = {b[2], b[1], b[0]};
            bus.code_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) bus.lz_en = ~bus.lz_en;
            @(negedge clk);
        end
        bus.code_valid = 1'b0;

        // Pending load then asynchronous reset during slot 1 DRIVE
        wait_to(((m_t / FRAME) + 1) * FRAME + 10);
        pulse_load(24'h60dab6);
        #2;
        rst = 1'b0;
        #1;
        check("async_seg", bus.seg, 8'hff);
        check("async_dig", {5'd0, bus.dig}, 8'h07);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.lz_en = 1'b0;
        lit("rel_s0", 2, 8'hff, 3'b110);
        lit("rel_s1", 10, 8'hff, 3'b101);
        lit("lost_load", 26, 8'hff, 3'b110);

        @(negedge clk);
        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
